// File: rtl/cskip_pkg.sv
// Shared defaults and the per-stage register record for the pipelined carry-skip adder.
package cskip_pkg;

  localparam int CSKIP_WIDTH  = 32;
  localparam int CSKIP_BLK    = 4;
  localparam int CSKIP_STAGES = 4;

  // One pipeline stage: lower sum slices already resolved, operands riding along for the upper slices.
  typedef struct packed {
    logic                   valid;
    logic [CSKIP_WIDTH-1:0] sum;
    logic [CSKIP_WIDTH-1:0] a;
    logic [CSKIP_WIDTH-1:0] b;
    logic                   carry;
  } stage_reg_t;

endpackage

// File: rtl/pipelined_carry_skip_adder_if.sv
// Valid/ready operand and result bus of the pipelined carry-skip adder.
// The ovf signal exists only when CSKIP_OVF_EN is defined.
interface pipelined_carry_skip_adder_if
  import cskip_pkg::*;
#(
  parameter int WIDTH = CSKIP_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CSKIP_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef CSKIP_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef CSKIP_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/carry_skip_block.sv
// Combinational BLK-bit ripple adder whose carry-out bypasses the ripple when every bit propagates.
module carry_skip_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
);
  logic [BLK-1:0] p;
  logic [BLK:0]   c;

  assign p = a ^ b;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BLK; i++) begin
      s[i]   = p[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
    end
    co = (&p) ? ci : c[BLK];
  end
endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// Adds one WIDTH/STAGES slice per stage; result STAGES cycles after acceptance, one per cycle.
// A single advance enable stalls every stage when the result is not taken; CSKIP_OVF_EN adds ovf.
module pipelined_carry_skip_adder
  import cskip_pkg::*;
#(
  parameter int WIDTH  = CSKIP_WIDTH,
  parameter int BLK    = CSKIP_BLK,
  parameter int STAGES = CSKIP_STAGES
) (
  input logic                         clk,
  input logic                         rst_n,
  pipelined_carry_skip_adder_if.slave bus
);
  localparam int S  = WIDTH / STAGES;
  localparam int NB = S / BLK;

  stage_reg_t st_q [STAGES];
  logic       advance;
`ifdef CSKIP_OVF_EN
  logic       ovf_q;
`endif

  if (WIDTH != CSKIP_WIDTH || (WIDTH % (STAGES * BLK)) != 0) begin : g_cfg_check
    $error("WIDTH must equal the record width and be divisible by STAGES*BLK");
  end

  assign advance      = !st_q[STAGES-1].valid || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_reg_t   src;
    stage_reg_t   nxt;
    logic [NB:0]  c;
    logic [S-1:0] slice_sum;

    if (k == 0) begin : g_head
      always_comb begin
        src       = '0;
        src.valid = bus.in_valid;
        src.a     = bus.a;
        src.b     = bus.b;
        src.carry = bus.cin;
      end
    end else begin : g_body
      assign src = st_q[k-1];
    end

    assign c[0] = src.carry;
    for (genvar j = 0; j < NB; j++) begin : g_blk
      carry_skip_block #(.BLK(BLK)) u_blk (
        .a  (src.a[k*S + j*BLK +: BLK]),
        .b  (src.b[k*S + j*BLK +: BLK]),
        .ci (c[j]),
        .s  (slice_sum[j*BLK +: BLK]),
        .co (c[j+1])
      );
    end

    always_comb begin
      nxt               = src;
      nxt.sum[k*S +: S] = slice_sum;
      nxt.carry         = c[NB];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q[k] <= '0;
      end else if (advance) begin
        st_q[k] <= nxt;
      end
    end

`ifdef CSKIP_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      // Carry into the MSB is recovered from the MSB operand and sum bits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= src.a[WIDTH-1] ^ src.b[WIDTH-1] ^ slice_sum[S-1] ^ c[NB];
        end
      end
    end
`endif
  end

  assign bus.out_valid = st_q[STAGES-1].valid;
  assign bus.sum       = st_q[STAGES-1].sum;
  assign bus.cout      = st_q[STAGES-1].carry;
`ifdef CSKIP_OVF_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Self-checking bench: directed vector table, random back-to-back traffic against an arithmetic model,
// output stall and mid-flight reset sequences.
module tb_pipelined_carry_skip_adder;
  import cskip_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_recv   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  int   recv_cyc[$];

  pipelined_carry_skip_adder_if #(.WIDTH(W)) bus ();

  pipelined_carry_skip_adder #(.WIDTH(W), .BLK(4), .STAGES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain 33-bit addition, signed overflow from operand/result signs.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic [32:0] t;
    exp_t        e;
    t      = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    e.sum  = t[31:0];
    e.cout = t[32];
    e.ovf  = (a[31] == b[31]) && (t[31] != a[31]);
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        recv_cyc.push_back(cyc);
        n_recv++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: out_valid with sum 0x%0h, required no result", bus.sum);
        end else begin
          e = exp_q.pop_front();
          check("model_sum", bus.sum, e.sum);
          check("model_cout", bus.cout, e.cout);
`ifdef CSKIP_OVF_EN
          check("model_ovf", bus.ovf, e.ovf);
`endif
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.cin));
    end
  end

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic cv);
    int w;
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = cv;
    w            = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("send_accepted", (w < 50), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    int   base;
    int   stale;
    logic [31:0] ra;

    tbl[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    tbl[4] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0};
    tbl[5] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    tbl[7] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[8] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_sum", bus.sum, 0);
    check("reset_cout", bus.cout, 0);
`ifdef CSKIP_OVF_EN
    check("reset_ovf", bus.ovf, 0);
`endif
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", bus.in_ready, 1);

    // Directed table: one op at a time, latency counted in cycles from the accepting cycle.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      int lat;
      bus.a        = tbl[i].a;
      bus.b        = tbl[i].b;
      bus.cin      = tbl[i].cin;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_sum", i), bus.sum, tbl[i].sum);
      check($sformatf("vec%0d_cout", i), bus.cout, tbl[i].cout);
`ifdef CSKIP_OVF_EN
      check($sformatf("vec%0d_ovf", i), bus.ovf, tbl[i].ovf);
`endif
      repeat (2) @(posedge clk);
      #1;
    end

    // Back-to-back random traffic, odd ops force full-width propagate.
    recv_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      if (i % 2 == 1) send(ra, ~ra, 1'($urandom_range(0, 1)));
      else            send(ra, $urandom, 1'($urandom_range(0, 1)));
    end
    repeat (8) @(posedge clk);
    #1;
    check("b2b_count", recv_cyc.size(), 16);
    if (recv_cyc.size() == 16) check("b2b_consecutive", recv_cyc[15] - recv_cyc[0], 15);
    check("b2b_drained", exp_q.size(), 0);

    // Output stall with a full pipe and a fifth op waiting.
    base          = n_recv;
    bus.out_ready = 1'b0;
    repeat (4) send($urandom, $urandom, 1'($urandom_range(0, 1)));
    check("stall_out_valid", bus.out_valid, 1);
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.cin      = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_hold_valid", bus.out_valid, 1);
      check("stall_hold_sum", bus.sum, exp_q[0].sum);
      check("stall_hold_cout", bus.cout, exp_q[0].cout);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("unstall_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("stall_no_loss", n_recv - base, 5);
    check("stall_drained", exp_q.size(), 0);

    // Reset with one result held at the output and three ops behind it.
    bus.out_ready = 1'b0;
    repeat (4) send($urandom, $urandom, 1'($urandom_range(0, 1)));
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_sum", bus.sum, 0);
    check("midrst_cout", bus.cout, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("midrst_no_stale", stale, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
